// File: rtl/score_digits_if.sv
// rtl/score_digits_if.sv - award/frame inputs and displayed-digit outputs of score_digits
interface score_digits_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    add_valid;
    logic [3:0]              add_val;
    logic                    clear;
    logic                    frame_start;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    busy;
    logic                    sat;

    modport master (
        output add_valid, add_val, clear, frame_start,
        input  digits, digit_en, busy, sat
    );

    modport slave (
        input  add_valid, add_val, clear, frame_start,
        output digits, digit_en, busy, sat
    );
endinterface

// File: rtl/score_digits.sv
// rtl/score_digits.sv - BCD score accumulator with per-frame display tally; SCORE_ZERO_BLANK_EN enables leading-zero blanking
module score_digits #(
    parameter int NUM_DIGITS = 4
) (
    input  logic          clk,
    input  logic          rst,
    score_digits_if.slave bus
);
    localparam int W = 4 * NUM_DIGITS;

    typedef enum logic {IDLE, TALLY} state_t;

    state_t         state;
    state_t         next_state;
    logic [W-1:0]   score;
    logic [W-1:0]   disp;
    logic [W-1:0]   disp_next;
    logic           sat;
    logic [3:0]     add_eff;
    logic [W:0]     add_res;
    logic [W:0]     inc_res;

    // Decimal add of a single 0..9 value; the carry ripples through every digit
    // and the top bit of the result is the carry out of the most significant digit.
    function automatic logic [W:0] bcd_add(input logic [W-1:0] a, input logic [3:0] b);
        logic [4:0]   s;
        logic         c;
        logic [W-1:0] r;
        c = 1'b0;
        r = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            s = {1'b0, a[4*i +: 4]} + {4'b0, c} + ((i == 0) ? {1'b0, b} : 5'd0);
            if (s > 5'd9) begin
                r[4*i +: 4] = 4'(s - 5'd10);
                c           = 1'b1;
            end else begin
                r[4*i +: 4] = s[3:0];
                c           = 1'b0;
            end
        end
        return {c, r};
    endfunction

    // Clamp the award to one decimal digit and form both BCD sums.
    always_comb begin
        add_eff = (bus.add_val > 4'd9) ? 4'd9 : bus.add_val;
        add_res = bcd_add(score, add_eff);
        inc_res = bcd_add(disp, 4'd1);
    end

    // True score and sticky saturation; clear wins over awards, saturation freezes awards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score <= '0;
            sat   <= 1'b0;
        end else if (bus.clear) begin
            score <= '0;
            sat   <= 1'b0;
        end else if (bus.add_valid && !sat) begin
            if (add_res[W]) begin
                score <= {NUM_DIGITS{4'h9}};
                sat   <= 1'b1;
            end else begin
                score <= add_res[W-1:0];
            end
        end
    end

    // Tally state and displayed score registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            disp  <= '0;
        end else begin
            state <= next_state;
            disp  <= disp_next;
        end
    end

    // Next tally state: the compare always sees the registered (pre-award) score,
    // so an award landing with frame_start only takes effect from the next frame.
    always_comb begin
        next_state = state;
        disp_next  = disp;
        case (state)
            IDLE: begin
                if (score != disp) next_state = TALLY;
            end
            TALLY: begin
                if (bus.frame_start) begin
                    disp_next = inc_res[W-1:0];
                    if (inc_res == {1'b0, score}) next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (bus.clear) begin
            next_state = IDLE;
            disp_next  = '0;
        end
    end

`ifdef SCORE_ZERO_BLANK_EN
    logic                  seen;
    logic [NUM_DIGITS-1:0] en;

    // A digit is shown once any digit at or above it is non-zero; the ones digit always shows.
    always_comb begin
        seen = 1'b0;
        en   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen  = seen | (disp[4*i +: 4] != 4'd0);
            en[i] = seen | (i == 0);
        end
    end

    assign bus.digit_en = en;
`else
    assign bus.digit_en = '1;
`endif

    assign bus.digits = disp;
    assign bus.busy   = (state == TALLY);
    assign bus.sat    = sat;
endmodule

// File: tb/tb_score_digits.sv
// tb/tb_score_digits.sv - scoreboard bench for score_digits
module tb_score_digits;
    localparam int ND = 4;

    typedef struct {
        logic [4*ND-1:0] digits;
        logic [ND-1:0]   en;
        logic            busy;
        logic            sat;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   maxv;
    int   m_score;
    int   m_disp;
    bit   m_sat;
    bit   m_tally;
    exp_t sb[$];
    exp_t e;

    score_digits_if #(.NUM_DIGITS(ND)) sif();

    score_digits #(.NUM_DIGITS(ND)) dut (
        .clk(clk),
        .rst(rst),
        .bus(sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4*ND-1:0] to_bcd(input int v);
        logic [4*ND-1:0] r;
        int d;
        d = v;
        r = '0;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(d % 10);
            d = d / 10;
        end
        return r;
    endfunction

    function automatic logic [ND-1:0] exp_en(input int v);
        logic [ND-1:0] r;
        int p;
        r = '1;
`ifdef SCORE_ZERO_BLANK_EN
        p = 1;
        for (int i = 0; i < ND; i++) begin
            r[i] = (i == 0) || (v >= p);
            p = p * 10;
        end
`endif
        return r;
    endfunction

    function automatic exp_t model_out();
        exp_t x;
        x.digits = to_bcd(m_disp);
        x.en     = exp_en(m_disp);
        x.busy   = m_tally;
        x.sat    = m_sat;
        return x;
    endfunction

    // One clock: drive inputs, advance the decimal model, queue the expected outputs.
    task automatic tick(input logic av, input logic [3:0] val, input logic clr, input logic fs);
        int  s;
        int  nd;
        bit  nt;
        @(negedge clk);
        sif.add_valid   = av;
        sif.add_val     = val;
        sif.clear       = clr;
        sif.frame_start = fs;
        if (clr) begin
            m_score = 0; m_disp = 0; m_sat = 0; m_tally = 0;
        end else begin
            nd = m_disp;
            nt = m_tally;
            if (m_tally && fs) begin
                nd = m_disp + 1;
                if (nd == m_score) nt = 0;
            end else if (!m_tally && m_score != m_disp) begin
                nt = 1;
            end
            if (av && !m_sat) begin
                s = m_score + ((val > 9) ? 9 : int'(val));
                if (s > maxv) begin
                    s = maxv;
                    m_sat = 1;
                end
                m_score = s;
            end
            m_disp  = nd;
            m_tally = nt;
        end
        sb.push_back(model_out());
        @(posedge clk);
        #1;
        sif.add_valid   = 1'b0;
        sif.add_val     = 4'd0;
        sif.clear       = 1'b0;
        sif.frame_start = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (sif.digits !== '0 || sif.busy !== 1'b0 || sif.sat !== 1'b0 || sif.digit_en !== exp_en(0)) begin
            errors++;
            $display("FAIL reset_initial: digits=%h busy=%b sat=%b en=%b, expected digits=0000 busy=0 sat=0 en=%b",
                     sif.digits, sif.busy, sif.sat, sif.digit_en, exp_en(0));
        end
        @(negedge clk);
        rst = 1'b0;
        tick(1'b1, 4'd5, 1'b0, 1'b0);
        tick(1'b0, 4'd0, 1'b0, 1'b0);
        tick(1'b0, 4'd0, 1'b0, 1'b1);
        tick(1'b0, 4'd0, 1'b0, 1'b1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (sif.digits !== e.digits && sb.size() == 0) begin
                errors++;
                $display("FAIL reset_pretally: digits=%h, expected %h", sif.digits, e.digits);
            end
        end
        #2;
        rst = 1'b1;
        m_score = 0; m_disp = 0; m_sat = 0; m_tally = 0;
        #1;
        checks++;
        if (sif.digits !== '0 || sif.busy !== 1'b0 || sif.sat !== 1'b0 || sif.digit_en !== exp_en(0)) begin
            errors++;
            $display("FAIL reset_async: digits=%h busy=%b sat=%b en=%b, expected digits=0000 busy=0 sat=0 en=%b",
                     sif.digits, sif.busy, sif.sat, sif.digit_en, exp_en(0));
        end
        @(negedge clk);
        rst = 1'b0;
        tick(1'b0, 4'd0, 1'b0, 1'b1);
        e = sb.pop_front();
        checks++;
        if (sif.digits !== e.digits || sif.busy !== e.busy) begin
            errors++;
            $display("FAIL reset_no_pending: digits=%h busy=%b, expected digits=%h busy=%b",
                     sif.digits, sif.busy, e.digits, e.busy);
        end
    endtask

    task automatic test_single_award();
        tick(1'b1, 4'd7, 1'b0, 1'b0);
        tick(1'b0, 4'd0, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) tick(1'b0, 4'd0, 1'b0, 1'b1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (sb.size() == 0 && (sif.digits !== e.digits || sif.busy !== e.busy || sif.digit_en !== e.en)) begin
                errors++;
                $display("FAIL single_award: digits=%h busy=%b en=%b, expected digits=%h busy=%b en=%b",
                         sif.digits, sif.busy, sif.digit_en, e.digits, e.busy, e.en);
            end
        end
        checks++;
        if (sif.digits !== 16'h0007 || sif.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_award_final: digits=%h busy=%b, expected digits=0007 busy=0", sif.digits, sif.busy);
        end
    endtask

    task automatic test_single_award_timing();
        tick(1'b0, 4'd0, 1'b1, 1'b0);
        tick(1'b1, 4'd7, 1'b0, 1'b0);
        e = sb.pop_front(); e = sb.pop_front();
        checks++;
        if (sif.busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_one_edge: busy=%b, expected 0", sif.busy);
        end
        tick(1'b0, 4'd0, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (sif.busy !== e.busy || sif.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_two_edges: busy=%b, expected 1", sif.busy);
        end
        for (int k = 0; k < 7; k++) begin
            tick(1'b0, 4'd0, 1'b0, 1'b1);
            e = sb.pop_front();
            checks++;
            if (sif.digits !== e.digits || sif.busy !== e.busy) begin
                errors++;
                $display("FAIL tally_frame%0d: digits=%h busy=%b, expected digits=%h busy=%b",
                         k, sif.digits, sif.busy, e.digits, e.busy);
            end
        end
    endtask

    task automatic test_simultaneous();
        tick(1'b0, 4'd0, 1'b1, 1'b0);
        tick(1'b1, 4'd5, 1'b1, 1'b0);
        tick(1'b0, 4'd0, 1'b0, 1'b0);
        tick(1'b0, 4'd0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            e = sb.pop_front();
            checks++;
            if (sb.size() == 0 && (sif.digits !== 16'h0000 || sif.busy !== 1'b0 || sif.busy !== e.busy)) begin
                errors++;
                $display("FAIL add_with_clear: digits=%h busy=%b, expected digits=0000 busy=0", sif.digits, sif.busy);
            end
        end
        tick(1'b1, 4'd3, 1'b0, 1'b1);
        tick(1'b0, 4'd0, 1'b0, 1'b1);
        for (int k = 0; k < 10 && (m_tally || m_score != m_disp); k++) begin
            tick(1'b0, 4'd0, 1'b0, 1'b1);
        end
        e = sb.pop_front();
        checks++;
        if (e.digits !== 16'h0000) begin
            errors++;
            $display("FAIL add_with_frame_model: model digits=%h, expected 0000", e.digits);
        end
        e = sb.pop_front();
        while (sb.size() > 1) e = sb.pop_front();
        e = sb.pop_front();
        checks++;
        if (sif.digits !== e.digits || sif.digits !== 16'h0003 || sif.busy !== 1'b0) begin
            errors++;
            $display("FAIL add_with_frame: digits=%h busy=%b, expected digits=0003 busy=0", sif.digits, sif.busy);
        end
    endtask

    task automatic test_carry();
        tick(1'b0, 4'd0, 1'b1, 1'b0);
        e = sb.pop_front();
        for (int k = 0; k < 111; k++) begin
            tick(1'b1, 4'd9, 1'b0, 1'b1);
            e = sb.pop_front();
            checks++;
            if (sif.digits !== e.digits || sif.busy !== e.busy) begin
                errors++;
                $display("FAIL carry_build: digits=%h busy=%b, expected digits=%h busy=%b",
                         sif.digits, sif.busy, e.digits, e.busy);
            end
        end
        for (int k = 0; k < 2000 && (m_tally || m_score != m_disp); k++) begin
            tick(1'b0, 4'd0, 1'b0, 1'b1);
            e = sb.pop_front();
            checks++;
            if (sif.digits !== e.digits || sif.busy !== e.busy || sif.digit_en !== e.en) begin
                errors++;
                $display("FAIL carry_tally: digits=%h busy=%b en=%b, expected digits=%h busy=%b en=%b",
                         sif.digits, sif.busy, sif.digit_en, e.digits, e.busy, e.en);
            end
        end
        checks++;
        if (sif.digits !== 16'h0999) begin
            errors++;
            $display("FAIL carry_base: digits=%h, expected 0999", sif.digits);
        end
        tick(1'b1, 4'd3, 1'b0, 1'b0);
        tick(1'b0, 4'd0, 1'b0, 1'b0);
        tick(1'b0, 4'd0, 1'b0, 1'b1);
        e = sb.pop_front(); e = sb.pop_front(); e = sb.pop_front();
        checks++;
        if (sif.digits !== 16'h1000 || sif.digits !== e.digits || sif.busy !== 1'b1) begin
            errors++;
            $display("FAIL carry_ripple: digits=%h busy=%b, expected digits=1000 busy=1", sif.digits, sif.busy);
        end
        for (int k = 0; k < 10 && m_tally; k++) begin
            tick(1'b0, 4'd0, 1'b0, 1'b1);
            e = sb.pop_front();
        end
        checks++;
        if (sif.digits !== 16'h1002 || sif.busy !== 1'b0) begin
            errors++;
            $display("FAIL carry_final: digits=%h busy=%b, expected digits=1002 busy=0", sif.digits, sif.busy);
        end
    endtask

    task automatic test_saturate();
        tick(1'b1, 4'd12, 1'b0, 1'b0);
        for (int k = 0; k < 30 && (m_tally || m_score != m_disp); k++) tick(1'b0, 4'd0, 1'b0, 1'b1);
        sb.delete();
        checks++;
        if (sif.digits !== 16'h1011) begin
            errors++;
            $display("FAIL clamp_12: digits=%h, expected 1011", sif.digits);
        end
        for (int k = 0; k < 998; k++) tick(1'b1, 4'd9, 1'b0, 1'b1);
        tick(1'b1, 4'd2, 1'b0, 1'b1);
        for (int k = 0; k < 12000 && (m_tally || m_score != m_disp); k++) tick(1'b0, 4'd0, 1'b0, 1'b1);
        e = sb[sb.size()-1];
        sb.delete();
        checks++;
        if (sif.digits !== 16'h9995 || sif.digits !== e.digits || sif.busy !== 1'b0) begin
            errors++;
            $display("FAIL reach_9995: digits=%h busy=%b, expected digits=9995 busy=0", sif.digits, sif.busy);
        end
        tick(1'b1, 4'd9, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if (sif.sat !== 1'b1 || sif.sat !== e.sat) begin
            errors++;
            $display("FAIL sat_set: sat=%b, expected 1", sif.sat);
        end
        for (int k = 0; k < 10 && (m_tally || m_score != m_disp); k++) tick(1'b0, 4'd0, 1'b0, 1'b1);
        tick(1'b1, 4'd1, 1'b0, 1'b0);
        tick(1'b0, 4'd0, 1'b0, 1'b1);
        tick(1'b0, 4'd0, 1'b0, 1'b1);
        while (sb.size() > 1) e = sb.pop_front();
        e = sb.pop_front();
        checks++;
        if (sif.digits !== 16'h9999 || sif.busy !== 1'b0 || sif.sat !== 1'b1 || sif.digits !== e.digits) begin
            errors++;
            $display("FAIL sat_hold: digits=%h busy=%b sat=%b, expected digits=9999 busy=0 sat=1",
                     sif.digits, sif.busy, sif.sat);
        end
        tick(1'b0, 4'd0, 1'b1, 1'b0);
        e = sb.pop_front();
        checks++;
        if (sif.digits !== 16'h0000 || sif.busy !== 1'b0 || sif.sat !== 1'b0 || sif.sat !== e.sat) begin
            errors++;
            $display("FAIL sat_clear: digits=%h busy=%b sat=%b, expected digits=0000 busy=0 sat=0",
                     sif.digits, sif.busy, sif.sat);
        end
    endtask

    task automatic test_blanking();
        logic [ND-1:0] want;
        tick(1'b1, 4'd9, 1'b0, 1'b0);
        tick(1'b1, 4'd9, 1'b0, 1'b0);
        tick(1'b1, 4'd9, 1'b0, 1'b0);
        tick(1'b1, 4'd9, 1'b0, 1'b0);
        tick(1'b1, 4'd4, 1'b0, 1'b0);
        for (int k = 0; k < 60 && (m_tally || m_score != m_disp); k++) begin
            tick(1'b0, 4'd0, 1'b0, 1'b1);
            e = sb[sb.size()-1];
            checks++;
            if (sif.digit_en !== e.en || sif.digits !== e.digits) begin
                errors++;
                $display("FAIL blank_tally: digits=%h en=%b, expected digits=%h en=%b",
                         sif.digits, sif.digit_en, e.digits, e.en);
            end
        end
        sb.delete();
`ifdef SCORE_ZERO_BLANK_EN
        want = 4'b0011;
`else
        want = 4'b1111;
`endif
        checks++;
        if (sif.digits !== 16'h0040 || sif.digit_en !== want) begin
            errors++;
            $display("FAIL blank_0040: digits=%h en=%b, expected digits=0040 en=%b", sif.digits, sif.digit_en, want);
        end
        tick(1'b0, 4'd0, 1'b1, 1'b0);
        e = sb.pop_front();
`ifdef SCORE_ZERO_BLANK_EN
        want = 4'b0001;
`else
        want = 4'b1111;
`endif
        checks++;
        if (sif.digit_en !== want || sif.digit_en !== e.en) begin
            errors++;
            $display("FAIL blank_0000: en=%b, expected en=%b", sif.digit_en, want);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        maxv = 1;
        for (int i = 0; i < ND; i++) maxv = maxv * 10;
        maxv = maxv - 1;
        m_score = 0; m_disp = 0; m_sat = 0; m_tally = 0;
        rst = 1'b1;
        sif.add_valid   = 1'b0;
        sif.add_val     = 4'd0;
        sif.clear       = 1'b0;
        sif.frame_start = 1'b0;
        #12;
        test_reset();
        test_single_award();
        test_single_award_timing();
        test_simultaneous();
        test_carry();
        test_saturate();
        test_blanking();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
